// File: rtl/mips_cpu_hilo_muldiv.sv
`timescale 1ns/1ps
// Purpose: iterative MULT/MULTU/DIV/DIVU unit that owns the HI/LO register pair, plus MTHI/MTLO writes.
// Latency: 33 cycles busy per operation (32 iterations + 1 fix-up); MTHI/MTLO visible one edge after the enable.
// Backpressure: busy stalls the pipeline; start/hi_we/lo_we are ignored while busy and are not queued.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   start, op, a, b       operation request (sampled in IDLE only), opcode, rs/rt operands
//   hi_we, lo_we, wdata   MTHI/MTLO writes from the ALU pass-through result
//   busy, done            operation in flight / one-cycle completion pulse (both registered)
//   hi, lo                HI/LO registers
module mips_cpu_hilo_muldiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [4:0]  cnt;
    logic        is_div;    // latched op[1]
    logic        neg_res;   // product / quotient must be negated at FIX
    logic        neg_rem;   // remainder must be negated at FIX (sign of dividend)
    logic        div_zero;  // divisor was zero
    logic [31:0] a_orig;    // raw dividend, returned in HI on divide by zero
    logic [31:0] opnd;      // multiplicand or divisor magnitude
    // Shared accumulator. Multiply: [64:32] running partial sum, [31:0] multiplier
    // shifted out from the bottom. Divide: [63:32] partial remainder, [31:0]
    // dividend shifting out of the top while quotient bits shift in at the bottom.
    logic [64:0] acc;

    // Operand preparation for a new operation
    logic        op_signed;
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    always_comb begin
        op_signed = ~op[0];
        abs_a     = (op_signed && a[31]) ? (~a + 32'd1) : a;
        abs_b     = (op_signed && b[31]) ? (~b + 32'd1) : b;
    end

    // One iteration step
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic [64:0] acc_step;

    always_comb begin
        mul_sum   = acc[64:32] + (acc[0] ? {1'b0, opnd} : 33'd0);
        div_shift = {acc[63:32], acc[31]};
        div_diff  = {1'b0, div_shift} - {2'b00, opnd};
        acc_step  = acc;
        if (is_div) begin
            // Restoring divide: keep the trial difference only when it is non-negative.
            // The remainder stays below the divisor, so 32 bits always hold it.
            if (!div_diff[33]) begin
                acc_step = {1'b0, div_diff[31:0], acc[30:0], 1'b1};
            end else begin
                acc_step = {1'b0, div_shift[31:0], acc[30:0], 1'b0};
            end
        end else begin
            acc_step = {1'b0, mul_sum, acc[31:1]};
        end
    end

    // Fix-up results
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    always_comb begin
        prod_fix = neg_res ? (~acc[63:0] + 64'd1) : acc[63:0];
        quo_fix  = neg_res ? (~acc[31:0] + 32'd1) : acc[31:0];
        rem_fix  = neg_rem ? (~acc[63:32] + 32'd1) : acc[63:32];
        res_hi   = prod_fix[63:32];
        res_lo   = prod_fix[31:0];
        if (is_div) begin
            if (div_zero) begin
                res_hi = a_orig;
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_hi = rem_fix;
                res_lo = quo_fix;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == 5'd31) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= 5'd0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            a_orig   <= 32'd0;
            opnd     <= 32'd0;
            acc      <= 65'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else begin
            busy <= (state_next != IDLE);
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        cnt      <= 5'd0;
                        is_div   <= op[1];
                        neg_res  <= op_signed && (a[31] ^ b[31]);
                        neg_rem  <= op_signed && op[1] && a[31];
                        div_zero <= (b == 32'd0);
                        a_orig   <= a;
                        if (op[1]) begin
                            opnd <= abs_b;
                            acc  <= {33'd0, abs_a};
                        end else begin
                            opnd <= abs_a;
                            acc  <= {33'd0, abs_b};
                        end
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    cnt <= cnt + 5'd1;   // wraps to 0 as RUN hands over to FIX
                end
                FIX: begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_hilo_muldiv.sv
`timescale 1ns/1ps
module tb_mips_cpu_hilo_muldiv;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec;
    int n_err;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    mips_cpu_hilo_muldiv dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge. Issues one operation, counts busy cycles, checks result.
    // disturb: pulse start/hi_we/lo_we mid-RUN. b2b: return on the done cycle so
    // the caller can start the next operation immediately.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input bit disturb, input bit b2b);
        int cycles;
        bit ended;
        start = 1'b1; op = o; a = av; b = bv;
        @(posedge clk);
        #1 start = 1'b0;
        cycles = 0;
        ended  = 1'b0;
        for (int i = 0; i < 100 && !ended; i++) begin
            @(negedge clk);
            if (disturb) begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
                if (cycles == 10) begin
                    start = 1'b1; op = ~o; a = 32'h5555_5555; b = 32'h3;
                    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
                end
            end
            if (busy) cycles++;
            else ended = 1'b1;
        end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        n_vec++;
        if (cycles !== 33 || !ended) begin
            n_err++;
            $display("FAIL %s busy_cycles: got %0d expected 33", name, cycles);
        end
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL %s done_pulse: got %b expected 1", name, done);
        end
        n_vec++;
        if (hi !== exp_hi) begin
            n_err++;
            $display("FAIL %s hi: got %h expected %h", name, hi, exp_hi);
        end
        n_vec++;
        if (lo !== exp_lo) begin
            n_err++;
            $display("FAIL %s lo: got %h expected %h", name, lo, exp_lo);
        end
        if (!b2b) begin
            @(negedge clk);
            n_vec++;
            if (done !== 1'b0) begin
                n_err++;
                $display("FAIL %s done_width: got %b expected 0", name, done);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h expected 0 0 0 0",
                     busy, done, hi, lo);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        run_op("mult_neg2x3",   OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0, 0);
        run_op("multu_max",     OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0);
        run_op("mult_min_sq",   OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0, 0);
    endtask

    task automatic test_div();
        run_op("div_neg7_2",    OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0);
        run_op("divu_100_7",    OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        0, 0);
        run_op("divu_by_zero",  OP_DIVU,  32'h1234_5678, 32'h0,         32'h1234_5678, 32'hFFFF_FFFF, 0, 0);
        run_op("div_by_zero",   OP_DIV,   32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 0, 0);
        run_op("div_overflow",  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, 0);
    endtask

    task automatic test_mthi_mtlo();
        hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 hi_we = 1'b0;
        @(negedge clk);
        n_vec++;
        if (hi !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL mthi: got %h expected deadbeef", hi);
        end
        lo_we = 1'b1; wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1 lo_we = 1'b0;
        @(negedge clk);
        n_vec++;
        if (lo !== 32'hCAFE_F00D || hi !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL mtlo: got hi=%h lo=%h expected deadbeef cafef00d", hi, lo);
        end
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0BAD_F00D;
        @(posedge clk);
        #1 begin hi_we = 1'b0; lo_we = 1'b0; end
        @(negedge clk);
        n_vec++;
        if (hi !== 32'h0BAD_F00D || lo !== 32'h0BAD_F00D) begin
            n_err++;
            $display("FAIL mthi_mtlo_both: got hi=%h lo=%h expected 0badf00d 0badf00d", hi, lo);
        end
    endtask

    task automatic test_stall();
        // 1000 / 33 = 30 remainder 10
        run_op("divu_disturbed", OP_DIVU, 32'd1000, 32'd33, 32'd10, 32'd30, 1, 0);
    endtask

    task automatic test_start_with_write();
        int cycles;
        start = 1'b1; op = OP_MULTU; a = 32'd2; b = 32'd3;
        hi_we = 1'b1; wdata = 32'h1111_1111;
        @(posedge clk);
        #1 begin start = 1'b0; hi_we = 1'b0; end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b1 || hi !== 32'h1111_1111) begin
            n_err++;
            $display("FAIL start_with_mthi_mid: got busy=%b hi=%h expected 1 11111111", busy, hi);
        end
        cycles = 1;
        for (int i = 0; i < 100 && busy; i++) begin
            @(negedge clk);
            if (busy) cycles++;
        end
        n_vec++;
        if (cycles !== 33 || hi !== 32'd0 || lo !== 32'd6 || done !== 1'b1) begin
            n_err++;
            $display("FAIL start_with_mthi_end: got cycles=%0d hi=%h lo=%h done=%b expected 33 0 6 1",
                     cycles, hi, lo, done);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        run_op("b2b_mult",      OP_MULT,  32'd7,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD, 0, 1);
        run_op("b2b_div",       OP_DIV,   32'd35,        32'hFFFF_FFFC, 32'h0000_0003, 32'hFFFF_FFF8, 0, 0);
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1; op = OP_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_err++;
            $display("FAIL reset_mid_run: got busy=%b done=%b hi=%h lo=%h expected 0 0 0 0",
                     busy, done, hi, lo);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_op("multu_6x7_after_reset", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 0, 0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_stall();
        test_start_with_write();
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
